// File: rtl/scoreboard_if.sv
// Issue/writeback/status bundle between the decode stage and the register scoreboard.
`timescale 1ns/1ps
interface scoreboard_if #(
  parameter int unsigned REG_ADDR_W = 5,
  parameter int unsigned NUM_REGS   = 32
);
  logic                  issue_valid;
  logic                  issue_ready;
  logic [REG_ADDR_W-1:0] issue_rs1;
  logic [REG_ADDR_W-1:0] issue_rs2;
  logic [REG_ADDR_W-1:0] issue_rd;
  logic                  issue_rd_we;
  logic                  issue_uses_rs2;
  logic                  wb_valid;
  logic [REG_ADDR_W-1:0] wb_rd;
  logic                  flush;
  logic [NUM_REGS-1:0]   busy_vec;
  logic [15:0]           stall_cycles;

  // Decode/writeback side: drives requests, observes readiness and status.
  modport master (
    output issue_valid, issue_rs1, issue_rs2, issue_rd, issue_rd_we, issue_uses_rs2,
    output wb_valid, wb_rd, flush,
    input  issue_ready, busy_vec, stall_cycles
  );

  // Scoreboard side.
  modport slave (
    input  issue_valid, issue_rs1, issue_rs2, issue_rd, issue_rd_we, issue_uses_rs2,
    input  wb_valid, wb_rd, flush,
    output issue_ready, busy_vec, stall_cycles
  );
endinterface

// File: rtl/scoreboard.sv
// Register scoreboard: per-register pending-write counters, issue hazard check
// with writeback bypass, registered busy vector and saturating stall counter.
`timescale 1ns/1ps
module scoreboard #(
  parameter int unsigned REG_ADDR_W = 5,
  parameter int unsigned NUM_REGS   = 32,
  parameter int unsigned CNT_W      = 2
) (
  input  logic clk,
  input  logic rst_n,
  scoreboard_if.slave sb
);

  localparam int unsigned STALL_W = 16;
  localparam logic [CNT_W-1:0]   CNT_MAX   = '1;
  localparam logic [STALL_W-1:0] STALL_MAX = '1;

  logic [CNT_W-1:0]   cnt_q [NUM_REGS];
  logic [CNT_W-1:0]   cnt_d [NUM_REGS];
  logic [NUM_REGS-1:0] busy_q, busy_d;
  logic [STALL_W-1:0]  stall_q, stall_d;

  logic [NUM_REGS-1:0] wb_hit;
  logic [NUM_REGS-1:0] hazard;
  logic [NUM_REGS-1:0] inc_vec;
  logic [NUM_REGS-1:0] dec_vec;
  logic rs1_haz, rs2_haz, rd_full;
  logic ready_c;
  logic fire;

  // Hazard detection; a same-cycle writeback to a register bypasses its hazard.
  always_comb begin
    wb_hit  = '0;
    hazard  = '0;
    rs1_haz = 1'b0;
    rs2_haz = 1'b0;
    rd_full = 1'b0;
    for (int unsigned i = 1; i < NUM_REGS; i++) begin
      wb_hit[i] = sb.wb_valid && (sb.wb_rd == REG_ADDR_W'(i));
      hazard[i] = (cnt_q[i] != '0) && !wb_hit[i];
      if (sb.issue_rs1 == REG_ADDR_W'(i)) rs1_haz = hazard[i];
      if (sb.issue_rs2 == REG_ADDR_W'(i)) rs2_haz = hazard[i];
      if (sb.issue_rd == REG_ADDR_W'(i))
        rd_full = sb.issue_rd_we && (cnt_q[i] == CNT_MAX) && !wb_hit[i];
    end
    ready_c = !rs1_haz && !(sb.issue_uses_rs2 && rs2_haz) && !rd_full;
    fire    = sb.issue_valid && ready_c;
  end

  // Next-state counters: flush wins; simultaneous issue and writeback cancel.
  always_comb begin
    inc_vec = '0;
    dec_vec = '0;
    busy_d  = '0;
    for (int unsigned i = 0; i < NUM_REGS; i++) begin
      cnt_d[i] = cnt_q[i];
    end
    for (int unsigned i = 1; i < NUM_REGS; i++) begin
      inc_vec[i] = fire && sb.issue_rd_we && (sb.issue_rd == REG_ADDR_W'(i));
      dec_vec[i] = wb_hit[i] && (cnt_q[i] != '0);
      if (sb.flush)
        cnt_d[i] = '0;
      else if (inc_vec[i] && !dec_vec[i])
        cnt_d[i] = cnt_q[i] + CNT_W'(1);
      else if (dec_vec[i] && !inc_vec[i])
        cnt_d[i] = cnt_q[i] - CNT_W'(1);
      busy_d[i] = (cnt_d[i] != '0);
    end
    cnt_d[0] = '0;

    stall_d = stall_q;
    if (sb.issue_valid && !ready_c && (stall_q != STALL_MAX))
      stall_d = stall_q + STALL_W'(1);
  end

  // State registers with immediate clear on reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < NUM_REGS; i++) cnt_q[i] <= '0;
      busy_q  <= '0;
      stall_q <= '0;
    end else begin
      for (int unsigned i = 0; i < NUM_REGS; i++) cnt_q[i] <= cnt_d[i];
      busy_q  <= busy_d;
      stall_q <= stall_d;
    end
  end

  assign sb.issue_ready  = ready_c;
  assign sb.busy_vec     = busy_q;
  assign sb.stall_cycles = stall_q;

endmodule

// File: tb/tb_scoreboard.sv
// Directed self-checking bench for the register scoreboard.
`timescale 1ns/1ps
module tb_scoreboard;

  logic clk;
  logic rst_n;
  int   n_assert;
  int   n_fail;

  scoreboard_if #(.REG_ADDR_W(5), .NUM_REGS(32)) sb_if ();

  scoreboard #(.REG_ADDR_W(5), .NUM_REGS(32), .CNT_W(2)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .sb    (sb_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [4:0] rs1, input logic [4:0] rs2,
                       input logic [4:0] rd, input logic we, input logic u2,
                       input logic wbv, input logic [4:0] wbrd, input logic fl);
    sb_if.issue_valid    = v;
    sb_if.issue_rs1      = rs1;
    sb_if.issue_rs2      = rs2;
    sb_if.issue_rd       = rd;
    sb_if.issue_rd_we    = we;
    sb_if.issue_uses_rs2 = u2;
    sb_if.wb_valid       = wbv;
    sb_if.wb_rd          = wbrd;
    sb_if.flush          = fl;
    #1;
  endtask

  task automatic idle();
    drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue rd with no sources, wait one edge.
  task automatic issue_rd(input logic [4:0] rd);
    drive(1'b1, 5'd0, 5'd0, rd, 1'b1, 1'b0, 1'b0, 5'd0, 1'b0);
    tick();
  endtask

  task automatic wb(input logic [4:0] rd);
    drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, rd, 1'b0);
    tick();
  endtask

  initial begin
    n_assert = 0;
    n_fail   = 0;
    rst_n    = 1'b0;
    idle();
    #12;
    chk("reset_busy", sb_if.busy_vec, 32'h0);
    chk("reset_stall", 32'(sb_if.stall_cycles), 32'h0);
    chk("reset_ready", 32'(sb_if.issue_ready), 32'h1);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // Issue to r5, then read r5 with and without bypassing writeback.
    drive(1'b1, 5'd0, 5'd0, 5'd5, 1'b1, 1'b0, 1'b0, 5'd0, 1'b0);
    chk("r5_issue_ready", 32'(sb_if.issue_ready), 32'h1);
    tick();
    chk("r5_busy", sb_if.busy_vec, 32'h0000_0020);
    drive(1'b1, 5'd5, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0);
    chk("r5_raw_stall", 32'(sb_if.issue_ready), 32'h0);
    drive(1'b1, 5'd5, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 5'd5, 1'b0);
    chk("r5_wb_bypass", 32'(sb_if.issue_ready), 32'h1);
    chk("r5_busy_still", sb_if.busy_vec, 32'h0000_0020);
    tick();
    chk("r5_cleared", sb_if.busy_vec, 32'h0);
    chk("r5_no_stall", 32'(sb_if.stall_cycles), 32'h0);

    // Register 0 is never busy.
    issue_rd(5'd0);
    chk("r0_busy", sb_if.busy_vec, 32'h0);
    drive(1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0);
    chk("r0_ready", 32'(sb_if.issue_ready), 32'h1);
    tick();
    chk("r0_busy2", sb_if.busy_vec, 32'h0);

    // Counter saturation on r7 (max 3 outstanding).
    issue_rd(5'd7);
    issue_rd(5'd7);
    issue_rd(5'd7);
    chk("r7_busy", sb_if.busy_vec, 32'h0000_0080);
    drive(1'b1, 5'd0, 5'd0, 5'd7, 1'b1, 1'b0, 1'b0, 5'd0, 1'b0);
    chk("r7_full_stall", 32'(sb_if.issue_ready), 32'h0);
    drive(1'b1, 5'd0, 5'd0, 5'd7, 1'b1, 1'b0, 1'b1, 5'd7, 1'b0);
    chk("r7_full_bypass", 32'(sb_if.issue_ready), 32'h1);
    tick();
    chk("r7_busy_after4", sb_if.busy_vec, 32'h0000_0080);
    wb(5'd7);
    chk("r7_wb1", sb_if.busy_vec, 32'h0000_0080);
    wb(5'd7);
    chk("r7_wb2", sb_if.busy_vec, 32'h0000_0080);
    wb(5'd7);
    chk("r7_wb3", sb_if.busy_vec, 32'h0);

    // Same-register issue+writeback cancels; writeback to idle reg ignored.
    issue_rd(5'd3);
    drive(1'b1, 5'd0, 5'd0, 5'd3, 1'b1, 1'b0, 1'b1, 5'd3, 1'b0);
    tick();
    chk("r3_cancel", sb_if.busy_vec, 32'h0000_0008);
    wb(5'd9);
    chk("r9_ignored", sb_if.busy_vec, 32'h0000_0008);
    drive(1'b1, 5'd0, 5'd0, 5'd10, 1'b1, 1'b0, 1'b1, 5'd3, 1'b0);
    tick();
    chk("r10_issue_r3_wb", sb_if.busy_vec, 32'h0000_0400);
    wb(5'd10);
    chk("r10_clear", sb_if.busy_vec, 32'h0);

    // rs2 hazard only matters when rs2 is used; stalls are counted.
    issue_rd(5'd4);
    drive(1'b1, 5'd0, 5'd4, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0);
    chk("rs2_unused_ready", 32'(sb_if.issue_ready), 32'h1);
    drive(1'b1, 5'd0, 5'd4, 5'd0, 1'b0, 1'b1, 1'b0, 5'd0, 1'b0);
    chk("rs2_used_stall", 32'(sb_if.issue_ready), 32'h0);
    tick();
    chk("stall_1", 32'(sb_if.stall_cycles), 32'h1);
    tick();
    chk("stall_2", 32'(sb_if.stall_cycles), 32'h2);
    wb(5'd4);
    chk("r4_clear", sb_if.busy_vec, 32'h0);

    // Flush beats concurrent issue and leaves stall count alone.
    issue_rd(5'd1);
    issue_rd(5'd2);
    issue_rd(5'd4);
    chk("busy_124", sb_if.busy_vec, 32'h0000_0016);
    drive(1'b1, 5'd0, 5'd0, 5'd6, 1'b1, 1'b0, 1'b0, 5'd0, 1'b1);
    tick();
    chk("flush_busy", sb_if.busy_vec, 32'h0);
    chk("flush_stall", 32'(sb_if.stall_cycles), 32'h2);
    idle();
    tick();
    chk("flush_r6_idle", sb_if.busy_vec, 32'h0);

    // Long stall on r12 saturates the counter; async reset clears mid-cycle.
    issue_rd(5'd12);
    drive(1'b1, 5'd12, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0);
    repeat (65540) @(posedge clk);
    #1;
    chk("stall_sat", 32'(sb_if.stall_cycles), 32'h0000_FFFF);
    chk("r12_busy", sb_if.busy_vec, 32'h0000_1000);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_busy", sb_if.busy_vec, 32'h0);
    chk("async_stall", 32'(sb_if.stall_cycles), 32'h0);
    chk("async_ready", 32'(sb_if.issue_ready), 32'h1);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    chk("post_rst_ready", 32'(sb_if.issue_ready), 32'h1);
    chk("post_rst_busy", sb_if.busy_vec, 32'h0);
    chk("post_rst_stall", 32'(sb_if.stall_cycles), 32'h0);
    idle();
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
